// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue feeding IF/ID; in-order word reads, redirect flush.
// Optional same-cycle response bypass when PFQ_BYPASS_EN is defined.
module ifetch_prefetch_queue #(
  parameter int            DEPTH    = 4,
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_rsp_valid,
  input  logic [31:0]   mem_rsp_data,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [31:0]   ir_data,
  output logic [AW-1:0] ir_npc,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  input  logic          halt,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   LIM  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C1   = CW'(1);
  localparam logic [AW-1:0] A1   = AW'(1);
  localparam logic [PW-1:0] P1   = PW'(1);

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] q_npc  [DEPTH];

  logic [CW:0] credit;
  logic        req_fire;
  logic        rsp_keep;
  logic        q_push;
  logic        q_pop;
  logic        q_nonempty;

  assign credit     = {1'b0, count} + {1'b0, inflight};
  assign q_nonempty = (count != '0);

  // Requests are held off in reset so nothing escapes before state is valid
  assign mem_req_valid = rst_n && !halt && !redir_valid
                       && (credit < LIM);
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign rsp_keep = mem_rsp_valid && (drop == '0)
                  && !redir_valid;
  assign q_pop    = q_nonempty && !redir_valid && ir_ready;
  assign busy     = (inflight != '0) || q_nonempty;

`ifdef PFQ_BYPASS_EN
  logic byp;

  assign byp      = !q_nonempty && rsp_keep;
  assign q_push   = rsp_keep && !(byp && ir_ready);
  assign ir_valid = (q_nonempty && !redir_valid) || byp;
  assign ir_data  = byp ? mem_rsp_data : q_data[rd_ptr];
  assign ir_npc   = byp ? rsp_pc + A1 : q_npc[rd_ptr];
`else
  assign q_push   = rsp_keep;
  assign ir_valid = q_nonempty && !redir_valid;
  assign ir_data  = q_data[rd_ptr];
  assign ir_npc   = q_npc[rd_ptr];
`endif

  // PCs, credit counters and queue pointers; redirect flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redir_valid) begin
      fetch_pc <= redir_pc;
      rsp_pc   <= redir_pc;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= inflight - (mem_rsp_valid ? C1 : '0);
      drop     <= inflight - (mem_rsp_valid ? C1 : '0);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + A1;
      if (rsp_keep) rsp_pc <= rsp_pc + A1;
      inflight <= inflight + (req_fire ? C1 : '0)
                - (mem_rsp_valid ? C1 : '0);
      if (mem_rsp_valid && (drop != '0))
        drop <= drop - C1;
      if (q_push) wr_ptr <= wr_ptr + P1;
      if (q_pop) rd_ptr <= rd_ptr + P1;
      unique case ({q_push, q_pop})
        2'b10:   count <= count + C1;
        2'b01:   count <= count - C1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared in reset so the head reads as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_npc[i]  <= '0;
      end
    end else if (q_push) begin
      q_data[wr_ptr] <= mem_rsp_data;
      q_npc[wr_ptr]  <= rsp_pc + A1;
    end
  end

  // Credit accounting must keep a push from landing in a full queue
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(q_push && !q_pop && (count == FULL))
  );

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Bench for ifetch_prefetch_queue: random traffic vs a transaction-level model.
// Memory returns Mem[a] = a*16 in order with random latency.
module tb_ifetch_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk;
  logic          rst_n;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          ir_valid;
  logic          ir_ready;
  logic [31:0]   ir_data;
  logic [AW-1:0] ir_npc;
  logic          redir_valid;
  logic [AW-1:0] redir_pc;
  logic          halt;
  logic          busy;

  ifetch_prefetch_queue #(
    .DEPTH(DEPTH), .AW(AW), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_data(ir_data), .ir_npc(ir_npc),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .halt(halt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] npc;
  } ins_t;

  req_t        oq[$];
  ins_t        iq[$];
  logic [31:0] m_fetch;
  int          n_tests;
  int          n_fail;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rd, input logic [31:0] rpc,
                      input bit hl, input int pr,
                      input int ps, input int pm);
    bit          rsp;
    bit          exp_req;
    bit          exp_irv;
    bit          fire;
    bit          st;
    logic [31:0] a;
    rsp = (oq.size() != 0) && ($urandom_range(99) < ps);
    redir_valid   = rd;
    redir_pc      = rpc;
    halt          = hl;
    ir_ready      = ($urandom_range(99) < pr);
    mem_req_ready = ($urandom_range(99) < pm);
    mem_rsp_valid = rsp;
    mem_rsp_data  = rsp ? oq[0].addr * 16 : $urandom;
    #1;
    exp_req = !hl && !rd && (iq.size() + oq.size() < DEPTH);
    exp_irv = (iq.size() != 0) && !rd;
    check("req_valid", mem_req_valid, exp_req);
    if (exp_req) check("req_addr", mem_req_addr, m_fetch);
    check("ir_valid", ir_valid, exp_irv);
    if (exp_irv) begin
      check("ir_data", ir_data, iq[0].data);
      check("ir_npc", ir_npc, iq[0].npc);
    end
    check("busy", busy, (iq.size() != 0) || (oq.size() != 0));
    fire = exp_req && mem_req_ready;
    a  = '0;
    st = 1'b0;
    if (rsp) begin
      a  = oq[0].addr;
      st = oq[0].stale;
      void'(oq.pop_front());
    end
    if (rd) begin
      iq.delete();
      for (int i = 0; i < oq.size(); i++) oq[i].stale = 1'b1;
      m_fetch = rpc;
    end else begin
      if (exp_irv && ir_ready) void'(iq.pop_front());
      if (rsp && !st) iq.push_back('{a * 16, a + 1});
      if (fire) begin
        oq.push_back('{m_fetch, 1'b0});
        m_fetch = m_fetch + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_ir_valid", ir_valid, 1'b0);
    check("rst_ir_data", ir_data, 32'h0);
    check("rst_ir_npc", ir_npc, 32'h0);
    check("rst_busy", busy, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    mem_rsp_valid = 1'b0;
    redir_valid   = 1'b0;
    halt          = 1'b0;
    #1;
    check_reset_outputs();
    oq.delete();
    iq.delete();
    m_fetch = '0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    m_fetch       = '0;
    rst_n         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    ir_ready      = 1'b0;
    redir_valid   = 1'b0;
    redir_pc      = '0;
    halt          = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // streaming with fast memory and eager consumer
    for (int i = 0; i < 30; i++) step(0, 0, 0, 100, 100, 100);
    // consumer stalled: queue fills, issue stops at credit cap
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 100, 100);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 100, 100, 100);
    // slow memory builds in-flight reads, then redirect
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 100);
    step(1, 32'h40, 0, 100, 0, 100);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 100, 60, 100);
    // redirect coinciding with a response
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 100);
    step(1, 32'h80, 0, 100, 100, 100);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 100, 100, 100);
    // halt drains, then resumes sequentially
    for (int i = 0; i < 12; i++) step(0, 0, 1, 100, 50, 100);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 100, 100, 100);
    // redirect while halted, back-to-back redirects
    step(1, 32'h200, 1, 100, 50, 100);
    step(1, 32'h300, 0, 100, 50, 100);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 100, 80, 100);
    // address wrap at the top of the space
    step(1, 32'hFFFF_FFFE, 0, 100, 100, 100);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 100, 100, 100);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit rd;
      rd = ($urandom_range(99) < 5);
      step(rd, $urandom_range(3) == 0 ? 32'hFFFF_FFFD : $urandom,
           ($urandom_range(99) < 10), 70, 60, 70);
    end
    // reset in the middle of traffic
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 50, 100);
    apply_reset();
    for (int i = 0; i < 200; i++)
      step(($urandom_range(99) < 5), $urandom, 0, 60, 60, 70);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch_queue.md
Name: ifetch_prefetch_queue

Overview:
Instruction prefetch unit that sits directly upstream of the IF/ID pipeline register. It issues in-order, word-addressed reads to instruction memory. It buffers the returned words with their next-PC value (address+1) in a small FIFO. It presents one instruction per cycle to the fetch stage over a valid/ready handshake. A taken branch in EX/MEM drives a redirect that flushes the queue and discards stale in-flight responses.

Parameters:
DEPTH, 4, queue entries; also the cap on buffered plus outstanding reads; power of 2, >= 2
AW, 32, PC / memory address width (word address)
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mem_req_valid  output  1  read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  AW  word address of request
mem_rsp_valid  input  1  read data returned; in order, no backpressure
mem_rsp_data  input  32  returned instruction word
ir_valid  output  1  instruction available to IF stage
ir_ready  input  1  IF stage consumes instruction
ir_data  output  32  instruction word (head of queue)
ir_npc  output  AW  address of that instruction + 1
redir_valid  input  1  taken-branch redirect (one-cycle pulse)
redir_pc  input  AW  branch target address
halt  input  1  stop issuing new requests (HLT retired)
busy  output  1  outstanding reads non-zero or queue non-empty

Behaviour:
- Reset (async, rst_n=0) clears all outputs and state:
  - mem_req_valid=0, ir_valid=0, busy=0; ir_data, ir_npc, mem_req_addr = 0.
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC; count, inflight and drop all 0.
- Reset mid-operation takes effect immediately. Responses still in flight from before reset are not tracked; memory is reset together with this block.
- Request issue:
  - mem_req_valid = !halt && !redir_valid && (count + inflight < DEPTH).
  - mem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += 1 (wraps mod 2^AW), inflight += 1.
- Response, when mem_rsp_valid:
  - inflight -= 1.
  - If drop > 0: data discarded, drop -= 1.
  - Otherwise push {mem_rsp_data, rsp_pc+1} and rsp_pc += 1.
  - Credit rule guarantees the queue is never full on push. An overflowing push is an assertion failure.
- Output side:
  - ir_valid = (count != 0) && !redir_valid.
  - ir_data / ir_npc come from the head entry.
  - Pop when ir_valid && ir_ready.
  - Latency: response sampled at edge N gives ir_valid=1 in the cycle after edge N.
- Simultaneous push and pop: count unchanged; allowed when full (the pop frees a slot).
- Redirect (redir_valid=1 at edge N):
  - Queue cleared (count=0, pointers reset).
  - fetch_pc=redir_pc, rsp_pc=redir_pc.
  - drop = inflight, minus 1 if a response arrives at edge N and drop was 0; otherwise that response is also dropped via the drop decrement.
  - No request and no pop during the redirect cycle. The first request to redir_pc is issued at the earliest on cycle N+1.
- Back-to-back redirects: each one recomputes drop from the current inflight. The last redirect wins.
- halt:
  - Blocks new requests only. In-flight responses still land and can be popped.
  - Deasserting halt resumes from fetch_pc.
  - Redirect while halted still updates fetch_pc.
- busy = (inflight != 0) || (count != 0).
- Widths: count, inflight and drop are $clog2(DEPTH)+1 bits. ir_npc is truncated to AW.

Optional Feature:
Macro PFQ_BYPASS_EN.
- Defined: when the queue is empty, drop==0, mem_rsp_valid=1 and redir_valid=0, the response is passed straight through in the same cycle:
  - ir_valid=1, ir_data=mem_rsp_data, ir_npc=rsp_pc+1.
  - If ir_ready=1 it is consumed with no push; otherwise it is pushed as normal.
  - Gives zero-cycle latency.
- Undefined: no combinational path from mem_rsp_* to ir_*; one-cycle latency as specified above.

Test Plan:
1. Reset, then memory with 1-cycle latency returning Mem[a]=a*16, ir_ready=1 -> requests at addresses 0,1,2,...; ir_data 0x0,0x10,0x20 with ir_npc 1,2,3 on consecutive cycles after the first fill.
2. ir_ready=0, DEPTH=4 -> exactly 4 requests issued, then mem_req_valid=0. Raise ir_ready -> 4 pops in order, then issue resumes at address 4.
3. Three reads in flight, redir_valid with redir_pc=0x40 -> queue empty next cycle and the 3 stale responses dropped. First ir_data is Mem[0x40] with ir_npc=0x41.
4. Redirect in the same cycle as a response arrival with inflight=1 -> that response dropped; drop=0 afterwards; next request address equals redir_pc.
5. halt=1 with 2 in flight -> no new requests; both instructions delivered; busy falls to 0. Release halt -> fetch resumes at the next sequential PC.
6. fetch_pc=2^AW-1 -> next request address 0; ir_npc for that instruction is 0.
